// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: synchronises inta_n and walks the two-pulse
// acknowledge cycle, emitting single-cycle strobes and the vector drive enable.
module inta_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    input  logic init_done,
    input  logic int_req,
    input  logic sngl,
    input  logic master,
    input  logic slave_sel,
    input  logic cas_match,
    output logic imp1,
    output logic end_imp1,
    output logic imp2,
    output logic end_imp2,
    output logic data_oe,
    output logic busy,
    output logic spurious,
    output logic seq_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        P1_LOW = 2'd1,
        GAP    = 2'd2,
        P2_LOW = 2'd3
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   inta_prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   oe_q;

    logic inta_s;
    logic fall_c;
    logic rise_c;
    logic drive_ok_c;

    assign inta_s     = sync_q[SYNC_STAGES-1];
    assign fall_c     = inta_prev_q & ~inta_s;
    assign rise_c     = ~inta_prev_q & inta_s;
    assign drive_ok_c = sngl | (master & ~slave_sel) | (~master & ~sngl & cas_match);

    // Vector drive drops the instant init_done is withdrawn.
    assign data_oe = oe_q & init_done;

    // Metastability synchroniser plus previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            inta_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], inta_n};
            inta_prev_q <= inta_s;
        end
    end

    // Acknowledge FSM with registered strobes, busy, drive enable and gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            oe_q     <= 1'b0;
            busy     <= 1'b0;
            imp1     <= 1'b0;
            end_imp1 <= 1'b0;
            imp2     <= 1'b0;
            end_imp2 <= 1'b0;
            spurious <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            imp1     <= 1'b0;
            end_imp1 <= 1'b0;
            imp2     <= 1'b0;
            end_imp2 <= 1'b0;
            spurious <= 1'b0;
            seq_err  <= 1'b0;
            if (!init_done) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                oe_q    <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fall_c) begin
                            state_q  <= P1_LOW;
                            busy     <= 1'b1;
                            imp1     <= 1'b1;
                            spurious <= ~int_req;
                        end
                    end
                    P1_LOW: begin
                        if (rise_c) begin
                            state_q  <= GAP;
                            end_imp1 <= 1'b1;
                            cnt_q    <= '0;
                        end
                    end
                    GAP: begin
                        if (fall_c) begin
                            state_q <= P2_LOW;
                            imp2    <= 1'b1;
                            oe_q    <= drive_ok_c;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                            seq_err <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    P2_LOW: begin
                        if (rise_c) begin
                            state_q  <= IDLE;
                            busy     <= 1'b0;
                            oe_q     <= 1'b0;
                            end_imp2 <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        oe_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: drives INTA waveforms, predicts per-cycle outputs
// from pin edge times (strobe = pin edge + 3 cycles) and compares windows.
module tb_inta_sequencer;

    localparam int unsigned TO   = 8;
    localparam int          MAXC = 16384;
    localparam int B_IMP1 = 7, B_END1 = 6, B_IMP2 = 5, B_END2 = 4;
    localparam int B_OE = 3, B_BUSY = 2, B_SPUR = 1, B_ERR = 0;

    logic clk = 1'b0;
    logic rst_n, inta_n, init_done, int_req, sngl, master, slave_sel, cas_match;
    logic imp1, end_imp1, imp2, end_imp2, data_oe, busy, spurious, seq_err;
    logic [7:0] outv;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [7:0] obs   [MAXC];
    logic [7:0] exp_v [MAXC];

    inta_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .inta_n(inta_n), .init_done(init_done),
        .int_req(int_req), .sngl(sngl), .master(master), .slave_sel(slave_sel),
        .cas_match(cas_match), .imp1(imp1), .end_imp1(end_imp1), .imp2(imp2),
        .end_imp2(end_imp2), .data_oe(data_oe), .busy(busy), .spurious(spurious),
        .seq_err(seq_err)
    );

    assign outv = {imp1, end_imp1, imp2, end_imp2, data_oe, busy, spurious, seq_err};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < MAXC) obs[cyc] = outv;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void exp_clear(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (c >= 0 && c < MAXC) exp_v[c] = 8'h00;
    endfunction

    function automatic void exp_pulse(input int c, input int b);
        if (c >= 0 && c < MAXC) exp_v[c][b] = 1'b1;
    endfunction

    function automatic void exp_span(input int lo, input int hi_excl, input int b);
        for (int c = lo; c < hi_excl; c++) if (c >= 0 && c < MAXC) exp_v[c][b] = 1'b1;
    endfunction

    // Full two-pulse acknowledge; expectations follow the pin edges by 3 cycles.
    task automatic drive_seq(input int l1, input int h, input int l2,
                             input bit oe, input bit spur, output int lo);
        int f1, r1, f2, r2;
        lo = cyc;
        f1 = cyc; inta_n = 1'b0; tick(l1);
        r1 = cyc; inta_n = 1'b1; tick(h);
        f2 = cyc; inta_n = 1'b0; tick(l2);
        r2 = cyc; inta_n = 1'b1; tick(5);
        exp_clear(lo, cyc);
        exp_pulse(f1 + 3, B_IMP1);
        if (spur) exp_pulse(f1 + 3, B_SPUR);
        exp_pulse(r1 + 3, B_END1);
        exp_pulse(f2 + 3, B_IMP2);
        exp_pulse(r2 + 3, B_END2);
        exp_span(f1 + 3, r2 + 3, B_BUSY);
        if (oe) exp_span(f2 + 3, r2 + 3, B_OE);
    endtask

    task automatic test_reset();
        int lo;
        rst_n = 1'b0; inta_n = 1'b1; init_done = 1'b0; int_req = 1'b0;
        sngl = 1'b0; master = 1'b0; slave_sel = 1'b0; cas_match = 1'b0;
        tick(3);
        checks++;
        if (outv !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", outv, 8'h00);
        end
        rst_n = 1'b1; init_done = 1'b1;
        lo = cyc;
        tick(6);
        exp_clear(lo, cyc);
        for (int c = lo; c < cyc; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_single();
        int lo;
        sngl = 1'b1; master = 1'b1; int_req = 1'b1; slave_sel = 1'b1; cas_match = 1'b0;
        drive_seq(4, 3, 4, 1'b1, 1'b0, lo);
        for (int c = lo; c < cyc; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin
                errors++;
                $display("FAIL single cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_master();
        int lo;
        sngl = 1'b0; master = 1'b1; int_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            slave_sel = (k == 0);
            drive_seq(3, 4, 3, (k != 0), 1'b0, lo);
            for (int c = lo; c < cyc; c++) begin
                checks++;
                if (obs[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL master_sel%0d cyc=%0d got=%b exp=%b", slave_sel, c, obs[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_slave();
        int lo;
        sngl = 1'b0; master = 1'b0; int_req = 1'b1; slave_sel = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cas_match = (k != 0);
            drive_seq(2, 5, 4, (k != 0), 1'b0, lo);
            for (int c = lo; c < cyc; c++) begin
                checks++;
                if (obs[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL slave_cas%0d cyc=%0d got=%b exp=%b", cas_match, c, obs[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int lo, f1, r1, f2, r2, f3, r3, hgap;
        sngl = 1'b1; int_req = 1'b1;
        // Longest legal gap: the fall is seen in the same cycle the counter hits the limit.
        drive_seq(2, TO + 1, 2, 1'b1, 1'b0, lo);
        for (int c = lo; c < cyc; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin
                errors++;
                $display("FAIL gap_limit cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            hgap = (k == 0) ? TO + 2 : $urandom_range(TO + 3, TO + 12);
            lo = cyc;
            f1 = cyc; inta_n = 1'b0; tick(3);
            r1 = cyc; inta_n = 1'b1; tick(hgap);
            f2 = cyc; inta_n = 1'b0; tick(2);
            r2 = cyc; inta_n = 1'b1; tick(3);
            f3 = cyc; inta_n = 1'b0; tick(2);
            r3 = cyc; inta_n = 1'b1; tick(5);
            exp_clear(lo, cyc);
            exp_pulse(f1 + 3, B_IMP1);
            exp_pulse(r1 + 3, B_END1);
            exp_pulse(r1 + 3 + TO + 1, B_ERR);
            exp_span(f1 + 3, r1 + 3 + TO + 1, B_BUSY);
            exp_pulse(f2 + 3, B_IMP1);
            exp_pulse(r2 + 3, B_END1);
            exp_pulse(f3 + 3, B_IMP2);
            exp_pulse(r3 + 3, B_END2);
            exp_span(f2 + 3, r3 + 3, B_BUSY);
            exp_span(f3 + 3, r3 + 3, B_OE);
            for (int c = lo; c < cyc; c++) begin
                checks++;
                if (obs[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL timeout_gap%0d cyc=%0d got=%b exp=%b", hgap, c, obs[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_spurious();
        int lo;
        sngl = 1'b1; int_req = 1'b0;
        drive_seq(3, 2, 3, 1'b1, 1'b1, lo);
        for (int c = lo; c < cyc; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin
                errors++;
                $display("FAIL spurious cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            end
        end
        int_req = 1'b1;
    endtask

    task automatic test_reset_mid();
        int lo, f1, r1, f2, g;
        sngl = 1'b1; int_req = 1'b1;
        lo = cyc;
        f1 = cyc; inta_n = 1'b0; tick(2);
        r1 = cyc; inta_n = 1'b1; tick(2);
        f2 = cyc; inta_n = 1'b0; tick(4);
        g = cyc; rst_n = 1'b0; inta_n = 1'b1; tick(3);
        rst_n = 1'b1; tick(6);
        exp_clear(lo, cyc);
        exp_pulse(f1 + 3, B_IMP1);
        exp_pulse(r1 + 3, B_END1);
        exp_pulse(f2 + 3, B_IMP2);
        exp_span(f1 + 3, g, B_BUSY);
        exp_span(f2 + 3, g, B_OE);
        for (int c = lo; c < cyc; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_init_drop(input bit in_p2);
        int lo, f1, r1, f2, g;
        sngl = 1'b1; int_req = 1'b1;
        f2 = 0;
        lo = cyc;
        f1 = cyc; inta_n = 1'b0; tick(2);
        r1 = cyc; inta_n = 1'b1;
        if (in_p2) begin
            tick(2);
            f2 = cyc; inta_n = 1'b0; tick(4);
        end else begin
            tick(5);
        end
        g = cyc; init_done = 1'b0; tick(2);
        inta_n = 1'b1; tick(3);
        inta_n = 1'b0; tick(2);
        inta_n = 1'b1; tick(3);
        inta_n = 1'b0; tick(4);
        init_done = 1'b1; tick(3);
        inta_n = 1'b1; tick(6);
        exp_clear(lo, cyc);
        exp_pulse(f1 + 3, B_IMP1);
        exp_pulse(r1 + 3, B_END1);
        exp_span(f1 + 3, g + 1, B_BUSY);
        if (in_p2) begin
            exp_pulse(f2 + 3, B_IMP2);
            exp_span(f2 + 3, g, B_OE);
        end
        for (int c = lo; c < cyc; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin
                errors++;
                $display("FAIL init_drop_p2_%0d cyc=%0d got=%b exp=%b", in_p2, c, obs[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_random();
        int lo, mode, l1, h, l2;
        bit oe, spur;
        for (int i = 0; i < 20; i++) begin
            mode      = $urandom_range(0, 2);
            sngl      = (mode == 0);
            master    = (mode == 1) ? 1'b1 : (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            slave_sel = 1'($urandom_range(0, 1));
            cas_match = 1'($urandom_range(0, 1));
            int_req   = ($urandom_range(0, 3) != 0);
            if (mode == 0)      oe = 1'b1;
            else if (mode == 1) oe = !slave_sel;
            else                oe = cas_match;
            spur = !int_req;
            l1 = $urandom_range(1, 6);
            h  = $urandom_range(1, TO + 1);
            l2 = $urandom_range(1, 6);
            drive_seq(l1, h, l2, oe, spur, lo);
            for (int c = lo; c < cyc; c++) begin
                checks++;
                if (obs[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL random%0d cyc=%0d got=%b exp=%b", i, c, obs[c], exp_v[c]);
                end
            end
        end
        int_req = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_master();
        test_slave();
        test_timeout();
        test_spurious();
        test_reset_mid();
        test_init_drop(1'b0);
        test_init_drop(1'b1);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
